pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline-stage register for the five-stage MIPS core, generalising the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width packed payload from an upstream stage to a downstream stage under a valid/ready handshake. It adds a synchronous flush for squashing, an optional skid entry so both handshake sides are registered, and an occupancy output. Each stage boundary in the core instantiates one copy, with the stage's control and data fields concatenated into `in_data`.

---
 rtl/pipe_stage_elastic_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 58 +++++
 rtl/pipe_stage_elastic.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic inter-stage registers of the five-stage MIPS core.
// Holds the stage occupancy encoding and the payload widths of each pipeline boundary.
package pipe_stage_elastic_pkg;

  // Encoding is {s_v, m_v}; 2'b10 never occurs because skid only fills behind main.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'b00,
    PS_ONE   = 2'b01,
    PS_TWO   = 2'b11
  } ps_state_e;

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 148;
  localparam int EXMEM_W = 107;
  localparam int MEMWB_W = 71;

  function automatic logic [1:0] occ_count(input logic m_v, input logic s_v);
    return {1'b0, m_v} + {1'b0, s_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of an elastic stage: a valid bit plus a DATA_W payload register.
// Priority is flush > load > drop; payload is zeroed on reset/flush only when CLEAR_DATA is set.
module pipe_slot #(
  parameter int DATA_W     = 32,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;

  // Valid bit of the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (drop) begin
      valid_r <= 1'b0;
    end
  end

  generate
    if (CLEAR_DATA) begin : g_clear
      // Payload register, cleared together with the valid bit.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_r <= {DATA_W{1'b0}};
        end else if (flush) begin
          data_r <= {DATA_W{1'b0}};
        end else if (load) begin
          data_r <= load_data;
        end
      end
    end else begin : g_keep
      // Payload register without reset; a squashed entry keeps its last value.
      always_ff @(posedge clk) begin
        if (load && !flush) begin
          data_r <= load_data;
        end
      end
    end
  endgenerate

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register between two MIPS core stages, with flush and
// an optional skid entry that makes in_ready a register (no out_ready -> in_ready path).
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SKID       = 1,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              acc_s;
  logic              pop_s;
  logic              in_ready_s;
  logic              m_v_s;
  logic              s_v_s;
  logic              m_load_s;
  logic              m_drop_s;
  logic [DATA_W-1:0] m_d_s;
  logic [DATA_W-1:0] m_load_data_s;

  assign acc_s = in_valid && in_ready_s;
  assign pop_s = m_v_s && out_ready;

  pipe_slot #(.DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .load      (m_load_s),
    .drop      (m_drop_s),
    .load_data (m_load_data_s),
    .valid     (m_v_s),
    .data      (m_d_s)
  );

  generate
    if (SKID != 0) begin : g_skid
      ps_state_e         state_s;
      ps_state_e         next_state_s;
      logic              s_load_s;
      logic              s_drop_s;
      logic              in_ready_r;
      logic [DATA_W-1:0] s_d_s;

      pipe_slot #(.DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .load      (s_load_s),
        .drop      (s_drop_s),
        .load_data (in_data),
        .valid     (s_v_s),
        .data      (s_d_s)
      );

      assign state_s = ps_state_e'({s_v_s, m_v_s});

      // Next occupancy state and slot controls; the slots apply flush themselves.
      always_comb begin
        next_state_s  = state_s;
        m_load_s      = 1'b0;
        m_drop_s      = 1'b0;
        s_load_s      = 1'b0;
        s_drop_s      = 1'b0;
        m_load_data_s = in_data;
        if (flush) begin
          next_state_s = PS_EMPTY;
        end else begin
          case (state_s)
            PS_EMPTY: begin
              if (acc_s) begin
                m_load_s     = 1'b1;
                next_state_s = PS_ONE;
              end else begin
                next_state_s = PS_EMPTY;
              end
            end
            PS_ONE: begin
              if (acc_s && pop_s) begin
                m_load_s     = 1'b1;
                next_state_s = PS_ONE;
              end else if (acc_s) begin
                s_load_s     = 1'b1;
                next_state_s = PS_TWO;
              end else if (pop_s) begin
                m_drop_s     = 1'b1;
                next_state_s = PS_EMPTY;
              end else begin
                next_state_s = PS_ONE;
              end
            end
            PS_TWO: begin
              if (pop_s) begin
                m_load_s      = 1'b1;
                m_load_data_s = s_d_s;
                s_drop_s      = 1'b1;
                next_state_s  = PS_ONE;
              end else begin
                next_state_s = PS_TWO;
              end
            end
            default: begin
              m_drop_s     = 1'b1;
              s_drop_s     = 1'b1;
              next_state_s = PS_EMPTY;
            end
          endcase
        end
      end

      // Registered ready: deasserted only while both entries are held.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_ready_r <= 1'b1;
        end else begin
          in_ready_r <= (next_state_s != PS_TWO);
        end
      end

      assign in_ready_s = in_ready_r;
    end else begin : g_single
      assign s_v_s      = 1'b0;
      assign in_ready_s = !m_v_s || out_ready;

      // Single entry: reload on accept, empty on a pop with nothing arriving.
      always_comb begin
        m_load_s      = acc_s;
        m_drop_s      = pop_s && !acc_s;
        m_load_data_s = in_data;
      end
    end
  endgenerate

  assign in_ready  = in_ready_s;
  assign out_valid = m_v_s;
  assign out_data  = m_d_s;
  assign occupancy = occ_count(m_v_s, s_v_s);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised scoreboard bench for pipe_stage_elastic across four parameter sets sharing one stimulus.
module tb_pipe_stage_elastic;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [511:0] in_data = 512'd0;

  logic         ov_w  [N];
  logic         ir_w  [N];
  logic [1:0]   occ_w [N];
  logic [511:0] od_w  [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per instance, a FIFO of accepted-but-not-yet-delivered items.
  logic [511:0] exp_mem  [N][0:7];
  int           wr_p     [N] = '{0, 0, 0, 0};
  int           rd_p     [N] = '{0, 0, 0, 0};
  logic         hold_chk [N] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [511:0] hold_val [N];

  always #5 clk = ~clk;

  function automatic int w_of(input int g);
    return (g == 2) ? 512 : ((g == 3) ? 1 : 32);
  endfunction

  function automatic logic skid_of(input int g);
    return (g != 1);
  endfunction

  function automatic logic cd_of(input int g);
    return (g < 2);
  endfunction

  function automatic logic [511:0] mask_of(input int g);
    logic [511:0] one;
    one = 512'd1;
    return (one << w_of(g)) - one;
  endfunction

  function automatic logic [511:0] rnd();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int W  = (g == 2) ? 512 : ((g == 3) ? 1 : 32);
      localparam int SK = (g == 1) ? 0 : 1;
      localparam bit CD = (g < 2);
      logic         ov_s;
      logic         ir_s;
      logic [1:0]   occ_s;
      logic [W-1:0] od_s;

      pipe_stage_elastic #(.DATA_W(W), .SKID(SK), .CLEAR_DATA(CD)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (ir_s),
        .in_data   (in_data[W-1:0]),
        .out_valid (ov_s),
        .out_ready (out_ready),
        .out_data  (od_s),
        .occupancy (occ_s)
      );

      assign ov_w[g]  = ov_s;
      assign ir_w[g]  = ir_s;
      assign occ_w[g] = occ_s;
      assign od_w[g]  = 512'(od_s);
    end
  endgenerate

  task automatic check(input string name, input int inst, input logic [511:0] act,
                       input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, inst, act, exp);
    end
  endtask

  // Monitor: at the negedge inputs and outputs equal what the next posedge will see.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int   sz;
      logic exp_ir;
      logic acc;
      logic pop;
      sz = wr_p[i] - rd_p[i];
      if (reset) begin
        rd_p[i]     = wr_p[i];
        hold_chk[i] = cd_of(i);
        hold_val[i] = 512'd0;
        check("rst_out_valid", i, 512'(ov_w[i]), 512'd0);
        check("rst_occupancy", i, 512'(occ_w[i]), 512'd0);
        check("rst_in_ready", i, 512'(ir_w[i]), 512'd1);
        if (cd_of(i)) check("rst_out_data", i, od_w[i], 512'd0);
      end else begin
        exp_ir = skid_of(i) ? (sz < 2) : ((sz == 0) || out_ready);
        check("out_valid", i, 512'(ov_w[i]), 512'(sz > 0));
        check("occupancy", i, 512'(occ_w[i]), 512'(sz));
        check("in_ready", i, 512'(ir_w[i]), 512'(exp_ir));
        if (sz > 0) check("out_data", i, od_w[i], exp_mem[i][rd_p[i] % 8]);
        else if (hold_chk[i]) check("idle_data", i, od_w[i], hold_val[i]);
        acc = in_valid && exp_ir;
        pop = (sz > 0) && out_ready;
        if (pop) rd_p[i]++;
        if (flush) begin
          rd_p[i]     = wr_p[i];
          hold_chk[i] = 1'b1;
          hold_val[i] = cd_of(i) ? 512'd0 : od_w[i];
        end else if (acc) begin
          exp_mem[i][wr_p[i] % 8] = in_data & mask_of(i);
          wr_p[i]++;
          hold_chk[i] = 1'b0;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [511:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #2;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    // streaming 0x1..0x10 with the sink always ready
    for (int k = 1; k <= 16; k++) step(1'b1, 512'(k), 1'b1, 1'b0);
    repeat (3) step(1'b0, 512'd0, 1'b1, 1'b0);
    // backpressure: two items held, then drained
    step(1'b1, 512'hA, 1'b0, 1'b0);
    step(1'b1, 512'hB, 1'b0, 1'b0);
    repeat (2) step(1'b0, 512'd0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 512'd0, 1'b1, 1'b0);
    // flush with both entries full and a competing input, then immediate reuse
    step(1'b1, 512'h1, 1'b0, 1'b0);
    step(1'b1, 512'h2, 1'b0, 1'b0);
    step(1'b1, 512'hC, 1'b0, 1'b1);
    step(1'b1, 512'hD, 1'b1, 1'b0);
    repeat (2) step(1'b0, 512'd0, 1'b1, 1'b0);
    // random traffic, ready toggling, occasional flush
    repeat (800) step(1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 31) == 0));
    // asynchronous reset mid-cycle with both entries held
    step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    #1 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (4) step(1'b1, rnd(), 1'b1, 1'b0);
    repeat (3) step(1'b0, 512'd0, 1'b1, 1'b0);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
